if_stage_pfq: RTL

//  Parametrised instruction-fetch stage with a prefetch queue. It keeps up to MAX_OUTSTANDING

---
 rtl/if_stage_pfq_pkg.sv | 19 +
 rtl/if_stage_pfq_if.sv | 27 ++
 rtl/if_stage_pfq_fetch_fifo.sv | 56 +++++
 rtl/if_stage_pfq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/if_stage_pfq_pkg.sv
// Shared types and constants for the prefetching instruction-fetch stage.
package if_stage_pfq_pkg;

    localparam int unsigned FS_TO_DS_BUS_WD  = 66;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [1:0]  INST_SIZE_WORD   = 2'h2;

    typedef struct packed {
        logic        ex;
        logic        adel;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_pfq_if.sv
// Handshake bundle of the fetch stage: redirect input, ID-side queue head and sram-like inst port.
interface if_stage_pfq_if;
    import if_stage_pfq_pkg::*;

    logic                       ds_allowin;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_req;
    logic [1:0]                 inst_size;
    logic [31:0]                inst_addr;
    logic [31:0]                inst_rdata;
    logic                       inst_addr_ok;
    logic                       inst_data_ok;

    modport master (
        input  ds_allowin, redirect_valid, redirect_pc, inst_rdata, inst_addr_ok, inst_data_ok,
        output fs_to_ds_valid, fs_to_ds_bus, inst_req, inst_size, inst_addr
    );

    modport slave (
        output ds_allowin, redirect_valid, redirect_pc, inst_rdata, inst_addr_ok, inst_data_ok,
        input  fs_to_ds_valid, fs_to_ds_bus, inst_req, inst_size, inst_addr
    );

endinterface

// File: rtl/if_stage_pfq_fetch_fifo.sv
// Small circular FIFO with synchronous flush; depth need not be a power of two.
module if_stage_pfq_fetch_fifo #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CntW-1:0]  count
);

    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             pop_ok, push_ok;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != DepthC) || pop_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/if_stage_pfq.sv
// Instruction fetch stage: keeps several sram-like requests in flight and queues words for ID.
module if_stage_pfq
    import if_stage_pfq_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    if_stage_pfq_if.master fs
);

    localparam int unsigned QCntW = $clog2(DEPTH + 1);
    localparam int unsigned OCntW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]                fetch_pc_q, fetch_pc_d;
    logic [31:0]                redir_pc_q, redir_pc_d;
    logic                       redir_pend_q, redir_pend_d;
    logic                       adel_done_q, adel_done_d;
    logic [OCntW-1:0]           discard_cnt_q, discard_cnt_d;
    logic [OCntW-1:0]           out_cnt, live_cnt;
    logic [QCntW-1:0]           q_count;
    logic [FS_TO_DS_BUS_WD-1:0] q_head;
    logic [31:0]                pc_head;
    fs_to_ds_t                  push_entry;
    logic aligned, has_space, fire, hold_req, resp, drop, resp_push, adel_push, q_push, q_pop;

    assign aligned  = is_word_aligned(fetch_pc_q);
    assign live_cnt = out_cnt - discard_cnt_q;
    // Every live request owns a queue slot, so a returning word always has room.
    assign has_space = (32'(live_cnt) + 32'(q_count)) < DEPTH;

    assign fs.inst_req  = !reset && aligned && (32'(out_cnt) < MAX_OUTSTANDING) && has_space;
    assign fs.inst_size = INST_SIZE_WORD;
    assign fs.inst_addr = fetch_pc_q;

    assign fire      = fs.inst_req && fs.inst_addr_ok;
    assign hold_req  = fs.inst_req && !fs.inst_addr_ok;
    assign resp      = fs.inst_data_ok && (out_cnt != '0);
    assign drop      = resp && (fs.redirect_valid || (discard_cnt_q != '0));
    assign resp_push = resp && !drop;
    assign adel_push = !fs.redirect_valid && !aligned && !adel_done_q &&
                       (out_cnt == discard_cnt_q) && (32'(q_count) < DEPTH);
    assign q_push    = resp_push || adel_push;

    assign fs.fs_to_ds_valid = (q_count != '0);
    assign fs.fs_to_ds_bus   = fs.fs_to_ds_valid ? q_head : '0;
    assign q_pop             = fs.fs_to_ds_valid && fs.ds_allowin;

    always_comb begin
        push_entry      = '0;
        push_entry.inst = fs.inst_rdata;
        push_entry.pc   = pc_head;
        if (adel_push) begin
            push_entry.ex   = 1'b1;
            push_entry.adel = 1'b1;
            push_entry.inst = '0;
            push_entry.pc   = fetch_pc_q;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        redir_pc_d    = redir_pc_q;
        redir_pend_d  = redir_pend_q;
        adel_done_d   = adel_done_q;
        discard_cnt_d = discard_cnt_q;
        if (fs.redirect_valid) begin
            // Everything still in flight, including a request accepted now, is on the old path.
            discard_cnt_d = out_cnt + OCntW'(fire) - OCntW'(resp);
            adel_done_d   = 1'b0;
            if (hold_req) begin
                redir_pend_d = 1'b1;
                redir_pc_d   = fs.redirect_pc;
            end else begin
                redir_pend_d = 1'b0;
                fetch_pc_d   = fs.redirect_pc;
            end
        end else begin
            discard_cnt_d = discard_cnt_q - OCntW'(drop);
            if (fire) begin
                if (redir_pend_q) begin
                    fetch_pc_d    = redir_pc_q;
                    redir_pend_d  = 1'b0;
                    discard_cnt_d = discard_cnt_d + OCntW'(1);
                end else begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            if (adel_push) adel_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            redir_pc_q    <= '0;
            redir_pend_q  <= 1'b0;
            adel_done_q   <= 1'b0;
            discard_cnt_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            redir_pc_q    <= redir_pc_d;
            redir_pend_q  <= redir_pend_d;
            adel_done_q   <= adel_done_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    if_stage_pfq_fetch_fifo #(
        .WIDTH (FS_TO_DS_BUS_WD),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fs.redirect_valid),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    // Occupancy of the in-order pc FIFO doubles as the outstanding-request count.
    if_stage_pfq_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (fire),
        .push_data (fetch_pc_q),
        .pop       (resp),
        .head_data (pc_head),
        .count     (out_cnt)
    );

endmodule
